pwm_demod: RTL and testbench

- Receive end of the audio PWM link. Recovers the WIDTH-bit sample value from a PWM waveform with a nominal frame of PERIOD clocks, such as the one driven by the team's PWM output module.
- Used for loopback verification of the audio path and for capturing external PWM audio into sample memory.
- Emits one sample per PWM frame with a one-cycle valid strobe, and reports lock and period-error status.

---
 rtl/pwm_demod.sv | 177 +++++++++++++++++
 tb/tb_pwm_demod.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_demod.sv
// pwm_demod -- receive end of the audio PWM link.
//
// Recovers a WIDTH-bit duty value from a PWM waveform with a nominal frame of
// PERIOD clocks. The duty is the number of high clocks counted from one rising
// edge (inclusive) to the next (exclusive). One sample is produced per frame,
// together with lock and frame-length error status.
//
// Ports:
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset
//   enable       in   synchronous run enable; low forces IDLE and clears counters
//   pwm_in       in   asynchronous PWM input
//   sample       out  last recovered duty value (saturates at 2^WIDTH-1)
//   sample_valid out  one-cycle strobe, sample updates in the same cycle
//   locked       out  last frame length was within PERIOD +/- TOL
//   period_err   out  one-cycle strobe, a frame ended outside PERIOD +/- TOL
module pwm_demod #(
    parameter int WIDTH       = 11,
    parameter int PERIOD      = 2048,
    parameter int TOL         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    output logic             locked,
    output logic             period_err
);

    // Two spare bits let the counters reach the 2*PERIOD timeout without wrapping.
    localparam int CW = WIDTH + 2;
    localparam logic [CW-1:0]    C_LAST_IDLE = CW'(PERIOD - 1);
    localparam logic [CW-1:0]    C_TIMEOUT   = CW'(2 * PERIOD);
    localparam logic [CW-1:0]    C_ONE       = CW'(1);
    localparam logic [WIDTH-1:0] C_FULL      = '1;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    // Clamp a high-clock count to the sample range.
    function automatic logic [WIDTH-1:0] sat_sample(input logic [CW-1:0] cnt);
        if (|cnt[CW-1:WIDTH]) begin
            return C_FULL;
        end
        return cnt[WIDTH-1:0];
    endfunction

    // Sample reported when no edge arrives: full scale for a stuck-high line.
    function automatic logic [WIDTH-1:0] static_sample(input logic lvl);
        return lvl ? C_FULL : '0;
    endfunction

    // Counters hold at all-ones rather than wrap.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
        return (&cnt) ? cnt : cnt + C_ONE;
    endfunction

    function automatic logic in_tol(input logic [CW-1:0] len);
        int l;
        l = int'(len);
        return (l >= PERIOD - TOL) && (l <= PERIOD + TOL);
    endfunction

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pwm_d;
    logic                   r_rise;
    logic                   w_pwm_s;
    logic                   w_rise;

    state_t                 r_state;
    logic [CW-1:0]          r_period_cnt;
    logic [CW-1:0]          r_high_cnt;
    logic [WIDTH-1:0]       r_sample;
    logic                   r_valid;
    logic                   r_locked;
    logic                   r_err;

    assign w_pwm_s = r_sync[SYNC_STAGES-1];
    assign w_rise  = w_pwm_s & ~r_pwm_d;

    // ---- stage 0: synchroniser and registered edge detect ----
    // r_pwm_d is the level aligned with r_rise, so the FSM counts high clocks
    // on the same timeline as the edge it reacts to. The chain ignores enable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync  <= '0;
            r_pwm_d <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_pwm_d <= w_pwm_s;
            r_rise  <= w_rise;
        end
    end

    // ---- stage 1: frame measurement FSM with registered outputs ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_sample     <= '0;
            r_valid      <= 1'b0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (!enable) begin
                // sample deliberately keeps its last value
                r_state      <= S_IDLE;
                r_period_cnt <= '0;
                r_high_cnt   <= '0;
                r_locked     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_locked <= 1'b0;
                        if (r_rise) begin
                            // first edge only opens a frame; nothing to report yet
                            r_state      <= S_MEASURE;
                            r_period_cnt <= C_ONE;
                            r_high_cnt   <= C_ONE;
                        end else if (r_period_cnt == C_LAST_IDLE) begin
                            r_sample     <= static_sample(r_pwm_d);
                            r_valid      <= 1'b1;
                            r_period_cnt <= '0;
                        end else begin
                            r_period_cnt <= sat_inc(r_period_cnt);
                        end
                    end
                    S_MEASURE: begin
                        // the rise is tested first so it wins over a coincident timeout
                        if (r_rise) begin
                            r_sample <= sat_sample(r_high_cnt);
                            r_valid  <= 1'b1;
                            if (in_tol(r_period_cnt)) begin
                                r_locked <= 1'b1;
                            end else begin
                                r_locked <= 1'b0;
                                r_err    <= 1'b1;
                            end
                            r_period_cnt <= C_ONE;
                            r_high_cnt   <= C_ONE;
                        end else if (r_period_cnt == C_TIMEOUT) begin
                            r_sample     <= static_sample(r_pwm_d);
                            r_valid      <= 1'b1;
                            r_err        <= 1'b1;
                            r_locked     <= 1'b0;
                            r_state      <= S_IDLE;
                            r_period_cnt <= '0;
                        end else begin
                            r_period_cnt <= sat_inc(r_period_cnt);
                            if (r_pwm_d) begin
                                r_high_cnt <= sat_inc(r_high_cnt);
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign locked       = r_locked;
    assign period_err   = r_err;

endmodule

// File: tb/tb_pwm_demod.sv
// Testbench for pwm_demod: table-driven frames, randomized frames checked by a
// frame-level reference model, and hand sequences for static input, timeout,
// asynchronous reset and enable handling.
module tb_pwm_demod;

    localparam int WIDTH       = 11;
    localparam int PERIOD      = 2048;
    localparam int TOL         = 16;
    localparam int SYNC_STAGES = 2;
    localparam int MAXS        = (1 << WIDTH) - 1;
    localparam int LAT         = SYNC_STAGES + 2;

    logic             clk = 1'b0;
    logic             resetn;
    logic             enable;
    logic             pwm_in;
    logic [WIDTH-1:0] sample;
    logic             sample_valid;
    logic             locked;
    logic             period_err;

    always #5 clk = ~clk;

    pwm_demod #(
        .WIDTH      (WIDTH),
        .PERIOD     (PERIOD),
        .TOL        (TOL),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .pwm_in      (pwm_in),
        .sample      (sample),
        .sample_valid(sample_valid),
        .locked      (locked),
        .period_err  (period_err)
    );

    typedef struct {
        int smp;
        bit err;
        bit lck;
    } exp_t;

    typedef struct {
        int len;
        int duty;
        int exp_smp;
        bit exp_err;
    } row_t;

    exp_t expq[$];
    int   vtimes[$];
    int   cyc     = 0;
    int   n_total = 0;
    int   n_pass  = 0;
    bit   prev_v  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int s, input bit er, input bit lk);
        exp_t e;
        e.smp = s;
        e.err = er;
        e.lck = lk;
        expq.push_back(e);
    endtask

    // Frame-level model: a frame of length len with duty high clocks reports
    // the duty (clamped), and is in error when its length misses PERIOD+/-TOL.
    function automatic exp_t model(input int len, input int duty);
        exp_t e;
        e.smp = (duty > MAXS) ? MAXS : duty;
        e.err = (len < PERIOD - TOL) || (len > PERIOD + TOL);
        e.lck = !e.err;
        return e;
    endfunction

    task automatic drive(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int len, input int duty);
        drive(1'b1, duty);
        drive(1'b0, len - duty);
    endtask

    // Closing rise reports the last frame, then the block is disabled.
    task automatic close_group(input string name);
        drive(1'b1, 1);
        drive(1'b0, 20);
        chk({name, "_drained"}, expq.size(), 0);
        enable = 1'b0;
        drive(1'b0, 5);
    endtask

    // Scoreboard: every strobe must match the next expected sample.
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (period_err) chk("err_with_valid", int'(sample_valid), 1);
            if (sample_valid) begin
                chk("no_back_to_back", int'(prev_v), 0);
                vtimes.push_back(cyc);
                if (expq.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_valid: got strobe with sample %0d at cycle %0d, required none",
                             sample, cyc);
                end else begin
                    e = expq.pop_front();
                    chk("sample", int'(sample), e.smp);
                    chk("period_err", int'(period_err), int'(e.err));
                    chk("locked", int'(locked), int'(e.lck));
                end
            end
            prev_v = sample_valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    initial begin
        row_t tbl[14];
        int   tr[14];
        int   nv;
        int   c0;
        int   t3;
        int   len;
        int   duty;

        resetn = 1'b0;
        enable = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sample", int'(sample), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(period_err), 0);
        resetn = 1'b1;
        @(negedge clk);

        // ---- table of frames: {len, duty, expected sample, expected error} ----
        tbl[0]  = '{2048, 512, 512, 1'b0};
        tbl[1]  = '{2048, 512, 512, 1'b0};
        tbl[2]  = '{2048, 512, 512, 1'b0};
        tbl[3]  = '{2048, 512, 512, 1'b0};
        tbl[4]  = '{2048, 100, 100, 1'b0};
        tbl[5]  = '{2048, 1900, 1900, 1'b0};
        tbl[6]  = '{2048, 1, 1, 1'b0};
        tbl[7]  = '{2048, 2047, 2047, 1'b0};
        tbl[8]  = '{2100, 1000, 1000, 1'b1};
        tbl[9]  = '{2100, 1000, 1000, 1'b1};
        tbl[10] = '{2048, 700, 700, 1'b0};
        tbl[11] = '{2032, 600, 600, 1'b0};
        tbl[12] = '{2065, 600, 600, 1'b1};
        tbl[13] = '{2100, 2060, 2047, 1'b1};

        enable = 1'b1;
        nv = vtimes.size();
        for (int i = 0; i < 14; i++) begin
            push(tbl[i].exp_smp, tbl[i].exp_err, !tbl[i].exp_err);
            tr[i] = cyc;
            frame(tbl[i].len, tbl[i].duty);
            if (i == 0) chk("first_rise_silent", vtimes.size() - nv, 0);
        end
        close_group("table");
        chk("table_count", vtimes.size() - nv, 14);
        if (vtimes.size() >= nv + 2) begin
            chk("rise_latency", vtimes[nv] - tr[1], LAT);
            chk("frame_spacing", vtimes[nv + 1] - vtimes[nv], PERIOD);
        end

        // ---- randomized frames against the model ----
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            len  = $urandom_range(PERIOD + 62, PERIOD - 58);
            duty = $urandom_range(len - 1, 1);
            expq.push_back(model(len, duty));
            frame(len, duty);
        end
        close_group("random");

        // ---- static low from IDLE ----
        enable = 1'b1;
        c0 = cyc;
        nv = vtimes.size();
        for (int i = 0; i < 4; i++) push(0, 1'b0, 1'b0);
        drive(1'b0, 10000);
        chk("static_low_count", vtimes.size() - nv, 4);
        if (vtimes.size() >= nv + 4) begin
            chk("static_low_first", vtimes[nv] - c0, PERIOD);
            chk("static_low_spacing", vtimes[nv + 3] - vtimes[nv + 2], PERIOD);
        end
        chk("static_low_drained", expq.size(), 0);
        enable = 1'b0;
        drive(1'b1, 10);

        // ---- static high from IDLE ----
        enable = 1'b1;
        c0 = cyc;
        nv = vtimes.size();
        for (int i = 0; i < 2; i++) push(MAXS, 1'b0, 1'b0);
        drive(1'b1, 4200);
        chk("static_high_count", vtimes.size() - nv, 2);
        if (vtimes.size() >= nv + 2) chk("static_high_first", vtimes[nv] - c0, PERIOD);
        chk("static_high_drained", expq.size(), 0);
        enable = 1'b0;
        drive(1'b0, 10);

        // ---- locked at 700, then stuck low: timeout then IDLE ----
        enable = 1'b1;
        push(700, 1'b0, 1'b1);
        push(700, 1'b0, 1'b1);
        frame(2048, 700);
        frame(2048, 700);
        t3 = cyc;
        nv = vtimes.size();
        push(0, 1'b1, 1'b0);
        push(0, 1'b0, 1'b0);
        drive(1'b1, 700);
        drive(1'b0, 2 * PERIOD + PERIOD + 30 - 700);
        chk("timeout_count", vtimes.size() - nv, 3);
        if (vtimes.size() >= nv + 3) begin
            chk("timeout_rise_latency", vtimes[nv] - t3, LAT);
            chk("timeout_delay", vtimes[nv + 1] - vtimes[nv], 2 * PERIOD);
            chk("idle_after_timeout", vtimes[nv + 2] - vtimes[nv + 1], PERIOD);
        end
        chk("timeout_locked", int'(locked), 0);
        chk("timeout_drained", expq.size(), 0);
        enable = 1'b0;
        drive(1'b0, 5);

        // ---- asynchronous reset mid-frame ----
        enable = 1'b1;
        push(300, 1'b0, 1'b1);
        push(300, 1'b0, 1'b1);
        frame(2048, 300);
        frame(2048, 300);
        drive(1'b1, 300);
        drive(1'b0, 500);
        chk("pre_reset_sample", int'(sample), 300);
        chk("pre_reset_locked", int'(locked), 1);
        #3;
        resetn = 1'b0;
        #1;
        chk("async_rst_sample", int'(sample), 0);
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_valid", int'(sample_valid), 0);
        chk("async_rst_err", int'(period_err), 0);
        @(negedge clk);
        resetn = 1'b1;

        // ---- enable dropped mid-frame, then restored ----
        drive(1'b0, 1248);
        drive(1'b1, 300);
        drive(1'b0, 1748);
        push(300, 1'b0, 1'b1);
        drive(1'b1, 400);
        drive(1'b0, 200);
        chk("post_reset_drained", expq.size(), 0);
        enable = 1'b0;
        nv = vtimes.size();
        drive(1'b0, 1448);
        drive(1'b1, 400);
        drive(1'b0, 1648);
        drive(1'b1, 400);
        drive(1'b0, 300);
        chk("disabled_no_strobe", vtimes.size() - nv, 0);
        chk("disabled_sample_holds", int'(sample), 300);
        chk("disabled_locked", int'(locked), 0);
        enable = 1'b1;
        drive(1'b0, 1348);
        drive(1'b1, 400);
        drive(1'b0, 100);
        chk("reenable_first_rise_silent", vtimes.size() - nv, 0);
        drive(1'b0, 1548);
        push(400, 1'b0, 1'b1);
        drive(1'b1, 1);
        drive(1'b0, 20);
        chk("reenable_second_rise", vtimes.size() - nv, 1);
        chk("reenable_drained", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
